cam_capture_px: RTL and testbench

Parametrised camera pixel-capture engine in the camera clock domain (clk = camera PCLK). It pairs 8-bit sensor bytes into 16-bit RGB565 pixels and frames them with VSYNC/HREF. It applies optional integer decimation and clipping, then emits framebuffer write strobes with a linear address. Supports continuous and single-shot (armed) capture. It sits between the SCCB configuration sequencer and the framebuffer write port (CDC FIFO or dual-port BRAM).

---
 rtl/cam_capture_px.sv | 155 +++++++++++++++
 tb/tb_cam_capture_px.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_px.sv
// Camera pixel capture in the PCLK domain. Sensor bytes are paired into RGB565
// pixels, then decimated and clipped, and written out as linear-address framebuffer writes.
module cam_capture_px #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int DECIM     = 2,
    parameter int ADDR_W    = 17,
    parameter int BYTE_SWAP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              single_shot,
    input  logic              arm,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              odd_err,
    output logic              clip_err
);

    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int RW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] H_LIM  = CW'(H_ACTIVE);
    localparam logic [RW-1:0] V_LIM  = RW'(V_ACTIVE);
    localparam logic [CW-1:0] C_MASK = CW'(DECIM - 1);
    localparam logic [RW-1:0] R_MASK = RW'(DECIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_ACTIVE} state_t;

    state_t            state_q;
    logic              vsync_q, href_q, phase_q, armed_q;
    logic [7:0]        byte_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_en_q, frame_done_q, odd_err_q, clip_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;

    logic              vs_fall, vs_rise, href_fall, line_end, in_range, decim_hit;
    logic [15:0]       pixel_d;
    logic [CW-1:0]     col_d;
    logic [RW-1:0]     row_d;
    logic [ADDR_W-1:0] addr_d;

    assign vs_fall   = vsync_q & ~vsync;
    assign vs_rise   = ~vsync_q & vsync;
    assign href_fall = href_q & ~href;
    // A frame end also closes the line that may still be open under href.
    assign line_end  = href_fall | vs_rise;

    assign pixel_d   = (BYTE_SWAP != 0) ? {cam_data, byte_q} : {byte_q, cam_data};
    assign in_range  = (col_q < H_LIM) && (row_q < V_LIM);
    assign decim_hit = ((col_q & C_MASK) == '0) && ((row_q & R_MASK) == '0);

    // Counters saturate: col/row only need to remember "at or past the limit".
    assign col_d  = (col_q == H_LIM) ? col_q : col_q + 1'b1;
    assign row_d  = (row_q == V_LIM) ? row_q : row_q + 1'b1;
    assign addr_d = (&addr_q) ? addr_q : addr_q + 1'b1;

    // wr_en is a one-cycle strobe qualifying wr_addr/wr_data; the sink has no
    // back-pressure and must accept every strobe.
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);
    assign odd_err    = odd_err_q;
    assign clip_err   = clip_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b1;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            armed_q      <= 1'b0;
            byte_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            odd_err_q    <= 1'b0;
            clip_err_q   <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            href_q       <= href;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;

            if (!enable) begin
                state_q <= S_IDLE;
                phase_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!single_shot || armed_q) state_q <= S_WAIT_VS;
                    end
                    S_WAIT_VS: begin
                        if (vs_fall) begin
                            state_q   <= S_ACTIVE;
                            armed_q   <= 1'b0;
                            col_q     <= '0;
                            row_q     <= '0;
                            phase_q   <= 1'b0;
                            addr_q    <= '0;
                            wr_addr_q <= '0;
                        end
                    end
                    S_ACTIVE: begin
                        if (line_end) begin
                            if (phase_q) odd_err_q <= 1'b1;
                            if (col_q != '0) row_q <= row_d;
                            phase_q <= 1'b0;
                            col_q   <= '0;
                            if (vs_rise) begin
                                frame_done_q <= 1'b1;
                                state_q      <= single_shot ? S_IDLE : S_WAIT_VS;
                            end
                        end else if (href) begin
                            if (!phase_q) begin
                                byte_q  <= cam_data;
                                phase_q <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                col_q   <= col_d;
                                if (!in_range) begin
                                    clip_err_q <= 1'b1;
                                end else if (decim_hit) begin
                                    wr_en_q   <= 1'b1;
                                    wr_data_q <= pixel_d;
                                    wr_addr_q <= addr_q;
                                    addr_q    <= addr_d;
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end

            if (arm) armed_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_capture_px.sv
// Bench for cam_capture_px: three configurations share one sensor stream and each
// is scored against a line-level model of the capture rules.
module tb_cam_capture_px;

    localparam int AW = 17;
    localparam int ND = 3;
    localparam int P_H  [ND] = '{4, 8, 4};
    localparam int P_V  [ND] = '{2, 4, 2};
    localparam int P_D  [ND] = '{1, 2, 1};
    localparam int P_SW [ND] = '{0, 0, 1};

    logic clk = 1'b0;
    logic reset, enable, single_shot, arm, vsync, href;
    logic [7:0] cam_data;

    logic          wr_en      [ND];
    logic [AW-1:0] wr_addr    [ND];
    logic [15:0]   wr_data    [ND];
    logic          frame_done [ND];
    logic          busy       [ND];
    logic          odd_err    [ND];
    logic          clip_err   [ND];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    cam_capture_px #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM(1), .ADDR_W(AW), .BYTE_SWAP(0)) u_d0 (
        .clk(clk), .reset(reset), .enable(enable), .single_shot(single_shot), .arm(arm),
        .vsync(vsync), .href(href), .cam_data(cam_data),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .frame_done(frame_done[0]),
        .busy(busy[0]), .odd_err(odd_err[0]), .clip_err(clip_err[0]));

    cam_capture_px #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .ADDR_W(AW), .BYTE_SWAP(0)) u_d1 (
        .clk(clk), .reset(reset), .enable(enable), .single_shot(single_shot), .arm(arm),
        .vsync(vsync), .href(href), .cam_data(cam_data),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .frame_done(frame_done[1]),
        .busy(busy[1]), .odd_err(odd_err[1]), .clip_err(clip_err[1]));

    cam_capture_px #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM(1), .ADDR_W(AW), .BYTE_SWAP(1)) u_d2 (
        .clk(clk), .reset(reset), .enable(enable), .single_shot(single_shot), .arm(arm),
        .vsync(vsync), .href(href), .cam_data(cam_data),
        .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .frame_done(frame_done[2]),
        .busy(busy[2]), .odd_err(odd_err[2]), .clip_err(clip_err[2]));

    // ---------------- scoreboard state ----------------
    logic [AW+15:0] exp_q0[$], exp_q1[$], exp_q2[$];
    logic [7:0]     lb[$];
    int             lens[$];
    int n_vec = 0;
    int n_err = 0;
    int m_row[ND], m_addr[ND], m_last[ND];
    int exp_wr[ND], act_wr[ND], exp_fd[ND], act_fd[ND];
    bit m_odd[ND], m_clip[ND];
    bit armed_tb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int q_size(input int i);
        case (i)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic void push_exp(input int i, input logic [AW+15:0] v);
        case (i)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endfunction

    function automatic logic [AW+15:0] pop_exp(input int i);
        case (i)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    // Reference model: n bytes of the current line (lb) reach the engine; ended
    // says whether the line closes normally (href fall) rather than by abort.
    function automatic void model_line(input int n, input bit ended);
        logic [15:0] pix;
        for (int i = 0; i < ND; i++) begin
            for (int c = 0; c < n / 2; c++) begin
                pix = (P_SW[i] != 0) ? {lb[2*c+1], lb[2*c]} : {lb[2*c], lb[2*c+1]};
                if (c >= P_H[i] || m_row[i] >= P_V[i]) begin
                    m_clip[i] = 1'b1;
                end else if ((c % P_D[i]) == 0 && (m_row[i] % P_D[i]) == 0) begin
                    push_exp(i, {AW'(m_addr[i]), pix});
                    m_last[i] = m_addr[i];
                    exp_wr[i]++;
                    if (m_addr[i] < (2 ** AW) - 1) m_addr[i]++;
                end
            end
            if (ended) begin
                if ((n % 2) != 0) m_odd[i] = 1'b1;
                if (n / 2 > 0) m_row[i]++;
            end
        end
    endfunction

    // Monitor: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ND; i++) begin
                if (frame_done[i]) act_fd[i]++;
                if (wr_en[i]) begin
                    act_wr[i]++;
                    check($sformatf("d%0d_wr_expected", i), 64'(q_size(i) != 0), 64'd1);
                    if (q_size(i) != 0)
                        check($sformatf("d%0d_wr_addr_data", i), {wr_addr[i], wr_data[i]}, pop_exp(i));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkpoint(input string name);
        bit exp_busy;
        exp_busy = enable && (!single_shot || armed_tb);
        for (int i = 0; i < ND; i++) begin
            check($sformatf("%s_d%0d_wr_count", name, i), act_wr[i], exp_wr[i]);
            check($sformatf("%s_d%0d_q_empty", name, i), q_size(i), 0);
            check($sformatf("%s_d%0d_frame_done", name, i), act_fd[i], exp_fd[i]);
            check($sformatf("%s_d%0d_odd_err", name, i), odd_err[i], m_odd[i]);
            check($sformatf("%s_d%0d_clip_err", name, i), clip_err[i], m_clip[i]);
            check($sformatf("%s_d%0d_busy", name, i), busy[i], exp_busy);
            check($sformatf("%s_d%0d_wr_addr", name, i), wr_addr[i], m_last[i]);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        armed_tb = 1'b1;
        tick();
    endtask

    // One frame: blanking, vsync fall, lines from lens[], vsync rise.
    task automatic run_frame(input string name, input bit fixed, input int drop_line,
                             input int drop_byte, input int arm_line);
        bit cap, aborted;
        enable = 1'b1;
        repeat (3) tick();
        cap = !single_shot || armed_tb;
        if (cap) begin
            if (single_shot) armed_tb = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_row[i] = 0; m_addr[i] = 0; m_last[i] = 0;
            end
        end
        aborted = 1'b0;
        vsync = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        for (int l = 0; l < lens.size(); l++) begin
            if (l == arm_line) begin
                arm = 1'b1;
                tick();
                arm = 1'b0;
                armed_tb = 1'b1;
            end
            lb.delete();
            for (int b = 0; b < lens[l]; b++) lb.push_back(fixed ? 8'(17 + b) : 8'($urandom));
            if (cap && !aborted) model_line((l == drop_line) ? drop_byte : lens[l], l != drop_line);
            for (int b = 0; b < lens[l]; b++) begin
                if (l == drop_line && b == drop_byte) begin
                    enable = 1'b0;
                    aborted = 1'b1;
                end
                href = 1'b1;
                cam_data = lb[b];
                tick();
            end
            href = 1'b0;
            cam_data = 8'($urandom);
            repeat ($urandom_range(2, 4)) tick();
        end
        vsync = 1'b1;
        if (cap && !aborted)
            for (int i = 0; i < ND; i++) exp_fd[i]++;
        repeat (5) tick();
        checkpoint(name);
    endtask

    task automatic rand_lens(input int max_lines);
        lens.delete();
        repeat ($urandom_range(1, max_lines)) lens.push_back($urandom_range(1, 20));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; enable = 1'b1; single_shot = 1'b0; arm = 1'b0;
        vsync = 1'b1; href = 1'b0; cam_data = 8'h00; armed_tb = 1'b0;
        for (int i = 0; i < ND; i++) begin
            m_row[i] = 0; m_addr[i] = 0; m_last[i] = 0; exp_wr[i] = 0; act_wr[i] = 0;
            exp_fd[i] = 0; act_fd[i] = 0; m_odd[i] = 1'b0; m_clip[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < ND; i++) begin
            check($sformatf("rst_d%0d_wr_en", i), wr_en[i], 0);
            check($sformatf("rst_d%0d_wr_addr", i), wr_addr[i], 0);
            check($sformatf("rst_d%0d_wr_data", i), wr_data[i], 0);
            check($sformatf("rst_d%0d_frame_done", i), frame_done[i], 0);
            check($sformatf("rst_d%0d_busy", i), busy[i], 0);
            check($sformatf("rst_d%0d_odd_err", i), odd_err[i], 0);
            check($sformatf("rst_d%0d_clip_err", i), clip_err[i], 0);
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < ND; i++) check($sformatf("rel_d%0d_busy", i), busy[i], 1);

        lens = '{8, 8};
        run_frame("full", 1'b1, -1, -1, -1);
        rand_lens(2);
        run_frame("restart", 1'b0, -1, -1, -1);
        lens = '{16, 16, 16, 16};
        run_frame("decim", 1'b0, -1, -1, -1);
        lens = '{7, 12};
        run_frame("odd_clip", 1'b1, -1, -1, -1);
        for (int f = 0; f < 6; f++) begin
            rand_lens(5);
            run_frame($sformatf("rand%0d", f), 1'b0, -1, -1, -1);
        end

        lens = '{8, 8, 8};
        run_frame("en_drop", 1'b0, 1, 5, -1);
        rand_lens(3);
        run_frame("en_resume", 1'b0, -1, -1, -1);

        enable = 1'b0;
        repeat (2) tick();
        single_shot = 1'b1;
        tick();
        rand_lens(3);
        run_frame("ss_noarm0", 1'b0, -1, -1, -1);
        rand_lens(3);
        run_frame("ss_noarm1", 1'b0, -1, -1, -1);
        pulse_arm();
        lens = '{8, 8};
        run_frame("ss_armed", 1'b0, -1, -1, -1);
        lens = '{6, 6, 6};
        run_frame("ss_arm_mid", 1'b0, -1, -1, 1);
        rand_lens(3);
        run_frame("ss_after_mid", 1'b0, -1, -1, -1);
        rand_lens(3);
        run_frame("ss_idle", 1'b0, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
